// File: rtl/stopwatch_display.sv
// Display stage of the stopwatch: samples the counter fields at a fixed refresh rate,
// converts each to two BCD digits with a subtract-by-ten engine and drives eight 7-seg digits.
module stopwatch_display #(
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] hour,
    input  logic [6:0] minute,
    input  logic [6:0] second,
    input  logic [7:0] m_sec,
    input  logic       lap,
    output logic [6:0] hex7,
    output logic [6:0] hex6,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       frozen,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   refresh_q, refresh_d;
    logic            lap_q, lap_d;
    logic            frozen_q, frozen_d;
    logic            busy_q, busy_d;
    logic [3:0][6:0] snap_q, snap_d;
    logic [6:0]      rem_q, rem_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      step_q, step_d;
    logic [1:0]      field_q, field_d;
    logic [7:0][3:0] dig_q, dig_d;
    logic [7:0][6:0] hex_q, hex_d;

    logic       tick;
    logic       lap_edge;
    logic       start;
    logic [6:0] rem_next;
    logic [3:0] tens_next;

    function automatic logic [6:0] sat99(input logic [7:0] v);
        return (v >= 8'd100) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (refresh_q == REFRESH_LAST);
        refresh_d = tick ? '0 : refresh_q + CW'(1);
        lap_d     = lap;
        lap_edge  = lap & ~lap_q;

        state_d  = state_q;
        frozen_d = frozen_q;
        busy_d   = busy_q;
        snap_d   = snap_q;
        rem_d    = rem_q;
        tens_d   = tens_q;
        step_d   = step_q;
        field_d  = field_q;
        dig_d    = dig_q;
        hex_d    = hex_q;
        start    = 1'b0;

        if (rem_q >= 7'd10) begin
            rem_next  = rem_q - 7'd10;
            tens_next = tens_q + 4'd1;
        end else begin
            rem_next  = rem_q;
            tens_next = tens_q;
        end

        case (state_q)
            S_IDLE: begin
                start = tick & ~frozen_q & ~lap_edge;
            end
            S_CONV: begin
                // Tenth step of a field: store its digits and load the next field.
                if (step_q == 4'd9) begin
                    dig_d[{field_q, 1'b0}] = tens_next;
                    dig_d[{field_q, 1'b1}] = rem_next[3:0];
                    rem_d   = snap_q[field_q + 2'd1];
                    tens_d  = '0;
                    step_d  = '0;
                    field_d = field_q + 2'd1;
                    if (field_q == 2'd3) begin
                        state_d = S_COMMIT;
                    end
                end else begin
                    rem_d  = rem_next;
                    tens_d = tens_next;
                    step_d = step_q + 4'd1;
                end
            end
            S_COMMIT: begin
                for (int i = 0; i < 8; i++) begin
                    hex_d[3'(7 - i)] = seg7(dig_q[3'(i)]);
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A lap edge outranks a tick; freezing also forces a fresh capture.
        if (lap_edge) begin
            frozen_d = ~frozen_q;
            start    = ~frozen_q;
        end

        if (start) begin
            snap_d[0] = sat99({1'b0, hour});
            snap_d[1] = sat99({1'b0, minute});
            snap_d[2] = sat99({1'b0, second});
            snap_d[3] = sat99(m_sec);
            rem_d     = sat99({1'b0, hour});
            tens_d    = '0;
            step_d    = '0;
            field_d   = '0;
            busy_d    = 1'b1;
            hex_d     = hex_q;
            state_d   = S_CONV;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            refresh_q <= '0;
            lap_q     <= 1'b0;
            frozen_q  <= 1'b0;
            busy_q    <= 1'b0;
            snap_q    <= '0;
            rem_q     <= '0;
            tens_q    <= '0;
            step_q    <= '0;
            field_q   <= '0;
            dig_q     <= '0;
            hex_q     <= {8{SEG_ZERO}};
        end else begin
            state_q   <= state_d;
            refresh_q <= refresh_d;
            lap_q     <= lap_d;
            frozen_q  <= frozen_d;
            busy_q    <= busy_d;
            snap_q    <= snap_d;
            rem_q     <= rem_d;
            tens_q    <= tens_d;
            step_q    <= step_d;
            field_q   <= field_d;
            dig_q     <= dig_d;
            hex_q     <= hex_d;
        end
    end

    assign hex7   = hex_q[7];
    assign hex6   = hex_q[6];
    assign hex5   = hex_q[5];
    assign hex4   = hex_q[4];
    assign hex3   = hex_q[3];
    assign hex2   = hex_q[2];
    assign hex1   = hex_q[1];
    assign hex0   = hex_q[0];
    assign frozen = frozen_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: directed scenarios plus random traffic, every cycle
// compared against a timeline model of captures, commits and the lap/freeze rules.
module tb_stopwatch_display;

    localparam int R = 64;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] hour = 7'd12;
    logic [6:0] minute = 7'd34;
    logic [6:0] second = 7'd56;
    logic [7:0] m_sec = 8'd78;
    logic       lap = 1'b0;
    logic [6:0] hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic       frozen, busy;
    logic [55:0] hex_all;

    int tests = 0;
    int fails = 0;

    logic [6:0] seg_tab [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

    always #5 clock = ~clock;

    stopwatch_display #(.REFRESH_CYCLES(R)) dut (
        .clock (clock),
        .reset (reset),
        .hour  (hour),
        .minute(minute),
        .second(second),
        .m_sec (m_sec),
        .lap   (lap),
        .hex7  (hex7),
        .hex6  (hex6),
        .hex5  (hex5),
        .hex4  (hex4),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .frozen(frozen),
        .busy  (busy)
    );

    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: digits shown, pending digits, commit edge, freeze flag.
    int m_edge = 0;
    int m_n = 0;
    int m_commit_at = 0;
    bit m_valid = 0;
    bit m_frozen = 0;
    bit m_busy = 0;
    bit m_lap_prev = 0;
    int m_disp [8];
    int m_pend [8];

    always @(posedge clock) begin : model
        bit le, tk, was_busy, cap;
        int vals [4];
        int v;
        m_edge++;
        if (reset) begin
            m_valid = 1;
            m_n = 0;
            m_frozen = 0;
            m_busy = 0;
            m_lap_prev = 0;
            for (int i = 0; i < 8; i++) m_disp[i] = 0;
        end else if (m_valid) begin
            le = lap && !m_lap_prev;
            m_lap_prev = lap;
            tk = (m_n % R) == R - 1;
            m_n++;
            was_busy = m_busy;
            cap = 0;
            if (le) begin
                if (!m_frozen) begin
                    m_frozen = 1;
                    cap = 1;
                end else begin
                    m_frozen = 0;
                end
            end else if (tk && !m_frozen && !was_busy) begin
                cap = 1;
            end
            if (cap) begin
                vals[0] = int'(hour);
                vals[1] = int'(minute);
                vals[2] = int'(second);
                vals[3] = int'(m_sec);
                for (int f = 0; f < 4; f++) begin
                    v = (vals[f] > 99) ? 99 : vals[f];
                    m_pend[2*f]     = v / 10;
                    m_pend[2*f + 1] = v % 10;
                end
                m_commit_at = m_edge + 41;
                m_busy = 1;
            end else if (was_busy && m_edge == m_commit_at) begin
                m_disp = m_pend;
                m_busy = 0;
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [55:0] exp_hex;
        if (m_valid) begin
            for (int i = 0; i < 8; i++) exp_hex[55 - 7*i -: 7] = seg_tab[m_disp[i]];
            check("model_hex", hex_all, exp_hex);
            check("model_frozen", 56'(frozen), 56'(m_frozen));
            check("model_busy", 56'(busy), 56'(m_busy));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Waits for busy to rise, counts how many cycles it stays high, returns at posedge+2.
    task automatic measure_busy(output int len);
        int k;
        len = 0;
        k = 0;
        @(negedge clock);
        while (busy !== 1'b1 && k < 4 * R) begin
            @(negedge clock);
            k++;
        end
        while (busy === 1'b1 && len < 200) begin
            len++;
            @(negedge clock);
        end
        #7;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour   = 7'(h);
        minute = 7'(m);
        second = 7'(s);
        m_sec  = 8'(c);
    endtask

    function automatic int pick(input int maxv);
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0: return 0;
            1: return 99;
            2: return 100;
            3: return 9 + $urandom_range(0, 1);
            default: return $urandom_range(0, maxv);
        endcase
    endfunction

    int len;
    int k;

    initial begin
        // Reset and first conversion
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        check("reset_hex", hex_all, {8{S0}});
        check("reset_busy", 56'(busy), 56'(0));
        check("reset_frozen", 56'(frozen), 56'(0));
        measure_busy(len);
        check("busy_len_first", 56'(len), 56'(41));
        check("disp_12_34_56_78", hex_all, {S1, S2, S3, S4, S5, S6, S7, S8});

        // Saturation of m_sec=100
        set_time(0, 59, 60, 100);
        measure_busy(len);
        check("busy_len_sat", 56'(len), 56'(41));
        check("disp_00_59_60_99", hex_all, {S0, S0, S5, S9, S6, S0, S9, S9});

        // Lap during a conversion restarts it with fresh inputs
        set_time(1, 2, 3, 4);
        k = 0;
        @(negedge clock);
        while (busy !== 1'b1 && k < 4 * R) begin
            @(negedge clock);
            k++;
        end
        #7;
        cyc(4);
        m_sec = 8'd5;
        cyc(1);
        lap = 1'b1;
        measure_busy(len);
        check("disp_lap_01_02_03_05", hex_all, {S0, S1, S0, S2, S0, S3, S0, S5});
        check("lap_frozen", 56'(frozen), 56'(1));
        for (int i = 0; i < 200; i++) begin
            set_time($urandom_range(0, 99), $urandom_range(0, 59), $urandom_range(0, 59),
                     $urandom_range(0, 99));
            if (i == 20) lap = 1'b0;
            cyc(1);
        end
        check("frozen_hold_hex", hex_all, {S0, S1, S0, S2, S0, S3, S0, S5});

        // Unfreeze: no immediate change, next tick shows current inputs
        set_time(23, 45, 7, 89);
        lap = 1'b1;
        cyc(2);
        check("unfreeze_frozen", 56'(frozen), 56'(0));
        check("unfreeze_no_change", hex_all, {S0, S1, S0, S2, S0, S3, S0, S5});
        measure_busy(len);
        check("disp_23_45_07_89", hex_all, {S2, S3, S4, S5, S0, S7, S8, S9});
        lap = 1'b0;
        cyc(3);

        // Lap edge on the tick cycle: one conversion, frozen
        set_time(11, 22, 33, 44);
        k = 0;
        while ((m_n % R) != R - 1 && k < 3 * R) begin
            cyc(1);
            k++;
        end
        lap = 1'b1;
        measure_busy(len);
        check("busy_len_lap_tick", 56'(len), 56'(41));
        check("lap_tick_frozen", 56'(frozen), 56'(1));
        check("disp_11_22_33_44", hex_all, {S1, S1, S2, S2, S3, S3, S4, S4});
        lap = 1'b0;
        cyc(3);
        lap = 1'b1;
        cyc(2);
        lap = 1'b0;
        cyc(2);

        // Reset 20 cycles into a lap-started conversion
        set_time(98, 76, 54, 32);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        cyc(20);
        check("pre_reset_busy", 56'(busy), 56'(1));
        check("pre_reset_frozen", 56'(frozen), 56'(1));
        reset = 1'b1;
        cyc(1);
        check("mid_reset_hex", hex_all, {8{S0}});
        check("mid_reset_busy", 56'(busy), 56'(0));
        check("mid_reset_frozen", 56'(frozen), 56'(0));
        reset = 1'b0;
        cyc(45);
        check("no_commit_after_reset", hex_all, {8{S0}});

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_time(pick(127), pick(127), pick(127), pick(255));
            if ($urandom_range(0, 39) == 0) lap = ~lap;
            reset = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        lap = 1'b0;
        cyc(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream stage of the stopwatch counter. It samples the binary hour/minute/second/centisecond fields at a fixed refresh rate and converts each field to two BCD digits with a sequential subtract-by-ten engine. It drives eight active-low seven-segment digits (HH MM SS CC) and provides a lap/freeze function that holds the displayed time while the counter keeps running.

## Interface
- REFRESH_CYCLES, 500000, clock cycles between display samples (100 Hz at 50 MHz); legal range ≥ 64.
- clock  input  1  system clock (50 MHz); sole clock of the block.
- reset  input  1  synchronous, active-high reset.
- hour  input  7  binary hours from the counter stage.
- minute  input  7  binary minutes.
- second  input  7  binary seconds.
- m_sec  input  8  binary centiseconds.
- lap  input  1  synchronous level from the lap button; each rising edge toggles freeze.
- hex7..hex0  output  7 each  segment drives, active-low, bit order {g,f,e,d,c,b,a}. hex7/hex6 show hours tens/units, hex5/hex4 minutes, hex3/hex2 seconds, hex1/hex0 centiseconds.
- frozen  output  1  high while the display is held by lap.
- busy  output  1  high while a conversion is in progress.

## Operation
- Refresh counter counts 0..REFRESH_CYCLES-1 and wraps. A tick occurs on the wrap cycle.
- Lap edge detection: register lap and treat lap & ~lap_q as the edge.
- FSM states:
  - IDLE:
    - A tick while not frozen: capture all four inputs into a snapshot and go to CONV.
    - A tick while frozen: ignored.
    - A tick while busy: ignored (dropped).
  - CONV: fields are processed in the order hour, minute, second, m_sec, with exactly 10 cycles per field. Each cycle: if the remainder is ≥ 10, subtract 10 and increment tens; otherwise hold. Tens and units are captured at the end of each field.
  - COMMIT: all eight hex outputs update together, then return to IDLE. Digits never show a partially converted time.
- Saturation: any snapshot field ≥ 100 is converted as 99. The counter can present m_sec = 100 for one tick, so this case must be handled.
- Lap edge while not frozen:
  - Set frozen.
  - Capture a fresh snapshot in the same cycle.
  - Abort any conversion in progress and restart CONV from the hour field.
  - The committed result stays on the display.
- Lap edge while frozen: clear frozen. The display resumes at the next tick; no immediate conversion.
- Lap edge on the same cycle as a tick: the lap action takes precedence; the tick is consumed.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset, including mid-conversion:
  - All hex outputs = 1000000 (display "00 00 00 00").
  - frozen = 0, busy = 0.
  - Refresh counter = 0, lap_q = 0.
  - FSM in IDLE; any conversion is discarded.

## Timing
- Capture occurs on edge E0, either a tick or a lap edge.
- busy is high from the cycle after E0 through the COMMIT cycle.
- Conversion runs from E1 to E40; hex outputs change on E41. Latency from capture to display is fixed at 41 cycles, independent of value.
- busy falls on E41.
- The first tick after reset release occurs REFRESH_CYCLES cycles after reset deasserts.
- Inputs are sampled only at capture, so the upstream stage may change them freely during conversion.
- frozen updates on the cycle after the lap edge is registered (the cycle where lap=1 and lap_q=0).

## Test plan
- Reset, then hour=12, minute=34, second=56, m_sec=78 with REFRESH_CYCLES=64 → 41 cycles after the first tick, hex7..hex0 show 1,2,3,4,5,6,7,8; busy high for exactly 41 cycles.
- m_sec=100, hour=0, minute=59, second=60 → display 00 59 60 99; no digit exceeds 9.
- Lap rise while a conversion of 01:02:03.04 is in flight, with inputs already at 01:02:03.05 → conversion restarts and the display commits 01:02:03.05. frozen=1; subsequent ticks with new inputs leave the digits unchanged.
- Second lap rise while frozen → frozen=0; no change until the next tick, then the current inputs are shown after 41 cycles.
- Lap edge coincident with a tick → exactly one conversion starts and frozen=1.
- Assert reset 20 cycles into a conversion → next cycle all hex = 1000000, busy=0, frozen=0; no commit follows.
